mmmu_arb_rr: RTL and testbench
==============================

Name: mmmu_arb_rr

Overview:
- Generalised MMMU dbus arbiter for NUM_REQ on-chip requesters (SPM, RVTU pairs, future DMA) in place of the fixed 2-bank arbiter.
- Sits between requesters and the MMMU bridge.
- Round-robin fair grant; multiple outstanding cacheline reads, tracked in issue order.
- Stamps each handshake frame with a requester tag, then steers read-response beats back to the issuing requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BRIDGE_WIDTH, 32, dbus beat width.
- MAX_RD_OUTSTANDING, 4, read-tag FIFO depth (power of two, >=1).
- TAG_W, $clog2(NUM_REQ), requester tag width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_vld  in  NUM_REQ  requester i has a pending request; held until acked.
- req_read  in  NUM_REQ  request i is cacheline read (1) or write-back (0); stable while req_vld.
- req_wdata  in  NUM_REQ*BRIDGE_WIDTH  flattened write/address beats, slice i.
- req_ack  out  NUM_REQ  one-hot/zero; bus ownership granted to requester i.
- rd_data  out  BRIDGE_WIDTH  read-response beat, broadcast.
- rd_data_vld  out  NUM_REQ  one-hot/zero; rd_data belongs to requester i.
- recv_data  in  BRIDGE_WIDTH  data from bridge.
- recv_data_vld  in  1  recv_data valid.
- bridge_ack  in  1  bridge grants on-chip ownership.
- bridge_fin  in  1  bridge finished current transaction.
- bridge_type  in  dbus_meta_t  type of current bridge transaction.
- arb_vld  out  1  an on-chip request is active.
- arb_pkt  out  BRIDGE_WIDTH  handshake frame or owned-bus data.
- rd_outstanding  out  $clog2(MAX_RD_OUTSTANDING+1)  reads awaiting response.

Behaviour:
- Reset: req_ack=0, rd_data_vld=0, arb_vld=0, arb_pkt=0, rd_outstanding=0, rr pointer=0, FIFO empty, FSM IDLE. Reset mid-transaction drops all state; no ack or data pulse in the reset cycle or the cycle after.
- FSM IDLE -> HANDSHAKE -> OWN -> IDLE.
- IDLE:
  - Eligible_i = req_vld[i] & !(req_read[i] & fifo_full).
  - Pick the first eligible index at or after rr_ptr, cyclic.
  - Register the winner's id, read bit and one-hot; go to HANDSHAKE next cycle.
  - No eligible requester: stay in IDLE, arb_pkt=0.
- HANDSHAKE:
  - arb_vld=1.
  - arb_pkt = dbus_pkt_cyc0_t with on_chip_req=1, on_chip_meta = cacheline_rd_req if read else cacheline_wb, on_chip_tag = winner id.
  - On bridge_ack: req_ack[winner]=1 combinationally, that cycle only; go to OWN.
  - If read, push winner id into the FIFO in the same cycle.
  - rr_ptr <= winner+1 mod NUM_REQ.
- OWN:
  - arb_vld=1; arb_pkt = req_wdata slice of the winner.
  - On bridge_fin: go to IDLE; arb_vld falls next cycle.
  - A new grant decision is made in IDLE, so there is a minimum 1-cycle gap between transactions.
- Read return:
  - Valid when bridge_type==cacheline_rd_resp and recv_data_vld.
  - rd_data=recv_data; rd_data_vld[fifo_head]=1; same-cycle, combinational.
  - bridge_fin with cacheline_rd_resp pops the FIFO, registered: head advances next cycle.
  - Response while FIFO empty: no rd_data_vld; assertion fires.
- Simultaneous push (ack of a read) and pop (fin of a read response): rd_outstanding is unchanged; FIFO pointers each advance; wrap modulo depth.
- bridge_ack outside HANDSHAKE and bridge_fin outside OWN/response are ignored (assertions).
- Read-response handling is independent of the ownership FSM.
- No X on outputs: rd_data=0 when no vld; arb_pkt=0 when IDLE.

Decomposition:
- mmmu_types gains:
  - on_chip_tag field (TAG_W, max 3 bits) in dbus_pkt_cyc0_t, taken from reserved bits.
  - arb_state_e {ARB_IDLE, ARB_HANDSHAKE, ARB_OWN}.
- Sub-module mmmu_arb_tag_fifo:
  - Parametrised synchronous FIFO of TAG_W entries, depth MAX_RD_OUTSTANDING.
  - Ports: push, pop, head, full, empty, count.
- Round-robin picker stays inline as a function.

Test Plan:
- Fairness:
  - Stimulus: NUM_REQ=4, req_vld=4'b1111 all writes, bridge_ack 2 cycles after arb_vld, fin 3 beats later, repeated 8 times.
  - Required: grant order 0,1,2,3,0,1,2,3; each req_ack is a 1-cycle pulse.
- Tag stamping:
  - Stimulus: single read from requester 2.
  - Required: HANDSHAKE arb_pkt has on_chip_req=1, on_chip_meta=cacheline_rd_req, on_chip_tag=2; after ack, arb_pkt equals req_wdata[2] until fin.
- Outstanding reads in order:
  - Stimulus: reads from requesters 1, then 3, then 0 acked and finished; then three rd_resp bursts of 4 beats.
  - Required: rd_data_vld goes to 1, then 3, then 0; rd_outstanding steps 3,2,1,0.
- FIFO full:
  - Stimulus: MAX_RD_OUTSTANDING=2, two reads outstanding; req 1 read and req 2 write pending.
  - Required: req 2 granted, req 1 not granted until the cycle after the first response fin.
- Simultaneous push/pop:
  - Stimulus: read ack in the same cycle as a rd_resp fin, count=1.
  - Required: count stays 1; the next response routes to the new tag.
- Reset in OWN:
  - Stimulus: rst asserted for 1 cycle in OWN with 2 reads outstanding.
  - Required: arb_vld=0, arb_pkt=0, rd_outstanding=0 next cycle; a later rd_resp produces no rd_data_vld.

Source files
------------

// File: rtl/mmmu_arb_rr_pkg.sv
// Shared dbus types for the MMMU on-chip arbiter.
// Frame layout, FSM states and frame builder.
package mmmu_arb_rr_pkg;

  localparam int PKT_W = 32;

  typedef enum logic [2:0] {
    DBUS_NONE         = 3'd0,
    CACHELINE_RD_REQ  = 3'd1,
    CACHELINE_WB      = 3'd2,
    CACHELINE_RD_RESP = 3'd3
  } dbus_meta_t;

  // Tag occupies formerly reserved bits above the meta field.
  typedef struct packed {
    logic [24:0] rsvd;
    logic [2:0]  on_chip_tag;
    dbus_meta_t  on_chip_meta;
    logic        on_chip_req;
  } dbus_pkt_cyc0_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HANDSHAKE,
    ARB_OWN
  } arb_state_e;

  function automatic logic [PKT_W-1:0] mk_cyc0(
    input logic       rd,
    input logic [2:0] tag
  );
    dbus_pkt_cyc0_t p;
    p = '0;
    p.on_chip_req  = 1'b1;
    p.on_chip_meta = rd ? CACHELINE_RD_REQ : CACHELINE_WB;
    p.on_chip_tag  = tag;
    return p;
  endfunction

endpackage

// File: rtl/mmmu_arb_rr_tag_fifo.sv
// In-order FIFO of requester tags for reads awaiting response.
// Head is valid only while not empty.
module mmmu_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_eff;
  logic          pop_eff;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign head     = mem[rd_ptr];

  function automatic logic [AW-1:0] nxt_ptr(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= nxt_ptr(wr_ptr);
      if (pop_eff)  rd_ptr <= nxt_ptr(rd_ptr);
      unique case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmmu_arb_rr.sv
// Round-robin MMMU dbus arbiter for NUM_REQ requesters with
// tagged, in-order steering of cacheline read responses.
module mmmu_arb_rr
  import mmmu_arb_rr_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int BRIDGE_WIDTH       = 32,
  parameter int MAX_RD_OUTSTANDING = 4,
  parameter bit ASSERT_EN          = 1'b1,
  localparam int TAG_W             = $clog2(NUM_REQ),
  localparam int CW                = $clog2(MAX_RD_OUTSTANDING + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_vld,
  input  logic [NUM_REQ-1:0]              req_read,
  input  logic [NUM_REQ*BRIDGE_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [BRIDGE_WIDTH-1:0]         rd_data,
  output logic [NUM_REQ-1:0]              rd_data_vld,
  input  logic [BRIDGE_WIDTH-1:0]         recv_data,
  input  logic                            recv_data_vld,
  input  logic                            bridge_ack,
  input  logic                            bridge_fin,
  input  dbus_meta_t                      bridge_type,
  output logic                            arb_vld,
  output logic [BRIDGE_WIDTH-1:0]         arb_pkt,
  output logic [CW-1:0]                   rd_outstanding
);

  arb_state_e         state;
  arb_state_e         nxt;
  logic [NUM_REQ-1:0] elig;
  logic [TAG_W:0]     pick;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   win_id;
  logic               win_read;
  logic [NUM_REQ-1:0] win_oh;
  logic               ack_fire;
  logic               push;
  logic               pop;
  logic               own_fin;
  logic               rsp_beat;
  logic               rsp_type;
  logic [TAG_W-1:0]   head;
  logic               full;
  logic               empty;

  // {found, index} of first eligible requester at or after ptr.
  function automatic logic [TAG_W:0] rr_pick(
    input logic [NUM_REQ-1:0] el,
    input logic [TAG_W-1:0]   ptr
  );
    logic [TAG_W:0] r;
    int             idx;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (el[idx]) r = {1'b1, TAG_W'(idx)};
    end
    return r;
  endfunction

  assign elig     = req_vld & ~(req_read & {NUM_REQ{full}});
  assign pick     = rr_pick(elig, rr_ptr);
  assign rsp_type = (bridge_type == CACHELINE_RD_RESP);
  assign ack_fire = (state == ARB_HANDSHAKE) & bridge_ack & ~rst;
  assign push     = ack_fire & win_read;
  assign pop      = bridge_fin & rsp_type & ~rst;
  assign own_fin  = (state == ARB_OWN) & bridge_fin & ~rsp_type;
  assign rsp_beat = rsp_type & recv_data_vld & ~empty & ~rst;

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ARB_IDLE:      if (pick[TAG_W]) nxt = ARB_HANDSHAKE;
      ARB_HANDSHAKE: if (bridge_ack)  nxt = ARB_OWN;
      ARB_OWN:       if (own_fin)     nxt = ARB_IDLE;
      default:       nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      win_id   <= '0;
      win_read <= 1'b0;
      win_oh   <= '0;
    end else begin
      if (state == ARB_IDLE && pick[TAG_W]) begin
        win_id   <= pick[TAG_W-1:0];
        win_read <= req_read[pick[TAG_W-1:0]];
        win_oh   <= NUM_REQ'(1) << pick[TAG_W-1:0];
      end
      if (ack_fire) begin
        rr_ptr <= (win_id == TAG_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      end
    end
  end

  always_comb begin
    arb_vld = 1'b0;
    arb_pkt = '0;
    req_ack = '0;
    unique case (state)
      ARB_HANDSHAKE: begin
        arb_vld = 1'b1;
        arb_pkt = BRIDGE_WIDTH'(mk_cyc0(win_read, 3'(win_id)));
        if (ack_fire) req_ack = win_oh;
      end
      ARB_OWN: begin
        arb_vld = 1'b1;
        arb_pkt = req_wdata[win_id*BRIDGE_WIDTH +: BRIDGE_WIDTH];
      end
      default: ;
    endcase
    rd_data     = rsp_beat ? recv_data : '0;
    rd_data_vld = rsp_beat ? (NUM_REQ'(1) << head) : '0;
  end

  mmmu_arb_tag_fifo #(
    .DEPTH (MAX_RD_OUTSTANDING),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (win_id),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (rd_outstanding)
  );

  always_ff @(posedge clk) begin
    if (ASSERT_EN && !rst) begin
      assert (!(bridge_ack && state != ARB_HANDSHAKE));
      assert (!(rsp_type && recv_data_vld && empty));
      assert (!(bridge_fin && state != ARB_OWN && !rsp_type));
    end
  end

endmodule

// File: tb/tb_mmmu_arb_rr.sv
// Directed + randomized bench for mmmu_arb_rr against a
// queue-based arbitration/response model.
module tb_mmmu_arb_rr;
  import mmmu_arb_rr_pkg::*;

  localparam int N = 4;
  localparam int BW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_vld;
  logic [N-1:0]  req_read;
  logic [N*BW-1:0] req_wdata;
  logic [N-1:0]  req_ack;
  logic [BW-1:0] rd_data;
  logic [N-1:0]  rd_data_vld;
  logic [BW-1:0] recv_data;
  logic          recv_data_vld;
  logic          bridge_ack;
  logic          bridge_fin;
  dbus_meta_t    bridge_type;
  logic          arb_vld;
  logic [BW-1:0] arb_pkt;
  logic [2:0]    rd_outstanding;

  mmmu_arb_rr #(
    .NUM_REQ            (N),
    .BRIDGE_WIDTH       (BW),
    .MAX_RD_OUTSTANDING (DEPTH),
    .ASSERT_EN          (1'b0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_vld        (req_vld),
    .req_read       (req_read),
    .req_wdata      (req_wdata),
    .req_ack        (req_ack),
    .rd_data        (rd_data),
    .rd_data_vld    (rd_data_vld),
    .recv_data      (recv_data),
    .recv_data_vld  (recv_data_vld),
    .bridge_ack     (bridge_ack),
    .bridge_fin     (bridge_fin),
    .bridge_type    (bridge_type),
    .arb_vld        (arb_vld),
    .arb_pkt        (arb_pkt),
    .rd_outstanding (rd_outstanding)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: rotating priority and issue-order tag queue.
  int rr = 0;
  int q[$];
  logic [N-1:0] pend = '0;
  logic [N-1:0] pend_rd = '0;
  logic [BW-1:0] wd [N];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (rr + i) % N;
      if (pend[k] && !(pend_rd[k] && q.size() == DEPTH)) return k;
    end
    return -1;
  endfunction

  task automatic bus_idle();
    bridge_ack = 1'b0;
    bridge_fin = 1'b0;
    recv_data_vld = 1'b0;
    recv_data = '0;
    bridge_type = DBUS_NONE;
  endtask

  task automatic drv();
    req_vld = pend;
    req_read = pend_rd;
    req_wdata = {wd[3], wd[2], wd[1], wd[0]};
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    bus_idle();
    drv();
    #1;
    chk(tag, {63'd0, arb_vld}, 64'd0);
  endtask

  // One full grant: IDLE, 3 HANDSHAKE cycles (ack on the 3rd),
  // 3 OWN beats (fin on the 3rd). pp drives a read-response fin
  // in the ack cycle; rst_own resets on the 2nd OWN beat.
  task automatic xact(input bit keep, input bit pp, input bit rst_own);
    int w;
    bit rd;
    logic [63:0] frame;
    w = model_pick();
    if (w < 0) begin
      checks++;
      failures++;
      $error("FAIL xact_no_winner observed=none expected=winner");
      return;
    end
    rd = pend_rd[w];
    frame = (64'(w) << 4) | (64'(rd ? 1 : 2) << 1) | 64'd1;
    @(negedge clk);
    bus_idle();
    drv();
    #1;
    chk("idle_vld", {63'd0, arb_vld}, 64'd0);
    chk("idle_pkt", 64'(arb_pkt), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus_idle();
      drv();
      if (c == 2) begin
        bridge_ack = 1'b1;
        if (pp) begin
          bridge_type = CACHELINE_RD_RESP;
          recv_data_vld = 1'b1;
          recv_data = $urandom;
          bridge_fin = 1'b1;
        end
      end
      #1;
      chk("hs_vld", {63'd0, arb_vld}, 64'd1);
      chk("hs_pkt", 64'(arb_pkt), frame);
      chk("hs_ack", 64'(req_ack), (c == 2) ? (64'd1 << w) : 64'd0);
      if (pp && c == 2)
        chk("pp_route", 64'(rd_data_vld), 64'd1 << q[0]);
    end
    if (pp) void'(q.pop_front());
    if (rd) q.push_back(w);
    rr = (w + 1) % N;
    if (!keep) pend[w] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bus_idle();
      bridge_type = rd ? CACHELINE_RD_REQ : CACHELINE_WB;
      wd[w] = $urandom;
      if (rst_own && b == 1) begin
        pend = '0;
        rst = 1'b1;
        bridge_type = CACHELINE_RD_RESP;
        recv_data_vld = 1'b1;
        recv_data = $urandom;
        drv();
        #1;
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_rdv", 64'(rd_data_vld), 64'd0);
        q.delete();
        rr = 0;
        @(negedge clk);
        rst = 1'b0;
        bus_idle();
        drv();
        #1;
        chk("post_rst_vld", {63'd0, arb_vld}, 64'd0);
        chk("post_rst_pkt", 64'(arb_pkt), 64'd0);
        chk("post_rst_cnt", 64'(rd_outstanding), 64'd0);
        chk("post_rst_rdv", 64'(rd_data_vld), 64'd0);
        return;
      end
      bridge_fin = (b == 2);
      drv();
      #1;
      chk("own_vld", {63'd0, arb_vld}, 64'd1);
      chk("own_pkt", 64'(arb_pkt), 64'(wd[w]));
      chk("own_ack", 64'(req_ack), 64'd0);
      chk("own_cnt", 64'(rd_outstanding), 64'(q.size()));
    end
  endtask

  task automatic resp(input int beats);
    logic [63:0] ev;
    for (int b = 0; b < beats; b++) begin
      @(negedge clk);
      bus_idle();
      drv();
      bridge_type = CACHELINE_RD_RESP;
      recv_data_vld = 1'b1;
      recv_data = $urandom;
      bridge_fin = (b == beats - 1);
      #1;
      ev = (q.size() > 0) ? (64'd1 << q[0]) : 64'd0;
      chk("rsp_cnt", 64'(rd_outstanding), 64'(q.size()));
      chk("rsp_vld", 64'(rd_data_vld), ev);
      chk("rsp_data", 64'(rd_data), (ev != 0) ? 64'(recv_data) : 64'd0);
    end
    if (q.size() > 0) void'(q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < N; i++) wd[i] = $urandom;
    rst = 1'b1;
    bus_idle();
    drv();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ack", 64'(req_ack), 64'd0);
    chk("reset_rdv", 64'(rd_data_vld), 64'd0);
    chk("reset_vld", {63'd0, arb_vld}, 64'd0);
    chk("reset_pkt", 64'(arb_pkt), 64'd0);
    chk("reset_cnt", 64'(rd_outstanding), 64'd0);
    rst = 1'b0;

    // Fairness: all four writing continuously.
    pend = 4'b1111;
    pend_rd = 4'b0000;
    for (int i = 0; i < 8; i++) xact(1'b1, 1'b0, 1'b0);
    pend = '0;
    idle_cycle("gap_idle");

    // Tag stamping on a single read from requester 2.
    pend = 4'b0100;
    pend_rd = 4'b0100;
    xact(1'b0, 1'b0, 1'b0);
    resp(4);

    // Three reads, responses return in issue order.
    pend_rd = 4'b1111;
    pend = 4'b0010; xact(1'b0, 1'b0, 1'b0);
    pend = 4'b1000; xact(1'b0, 1'b0, 1'b0);
    pend = 4'b0001; xact(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) resp(4);
    @(negedge clk);
    #1;
    chk("drained_cnt", 64'(rd_outstanding), 64'd0);

    // FIFO full: reads blocked, write still granted.
    for (int i = 0; i < DEPTH; i++) begin
      pend = 4'(1 << i);
      xact(1'b0, 1'b0, 1'b0);
    end
    pend = 4'b0110;
    pend_rd = 4'b0010;
    xact(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_cycle("full_blocked");
    resp(4);
    xact(1'b0, 1'b0, 1'b0);
    while (q.size() > 0) resp(2);

    // Push and pop in the same cycle at count 1.
    pend_rd = 4'b1111;
    pend = 4'b0001; xact(1'b0, 1'b0, 1'b0);
    pend = 4'b0100; xact(1'b0, 1'b1, 1'b0);
    resp(3);

    // Randomized mix of grants and responses.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0 && q.size() > 0) begin
        pend = '0;
        resp($urandom_range(1, 4));
      end else begin
        pend = 4'($urandom_range(1, 15));
        pend_rd = 4'($urandom_range(0, 15));
        if (model_pick() < 0) begin
          pend = '0;
          resp($urandom_range(1, 4));
        end else begin
          xact(1'b0, (q.size() > 0) && ($urandom_range(0, 1) == 1), 1'b0);
        end
      end
    end
    pend = '0;
    while (q.size() > 0) resp(1);

    // Reset while owning with two reads outstanding.
    pend_rd = 4'b1111;
    pend = 4'b0010; xact(1'b0, 1'b0, 1'b0);
    pend = 4'b0001; xact(1'b0, 1'b0, 1'b1);
    resp(2);
    idle_cycle("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
